pt_decoder: RTL

Receive-side companion to the PT2262 code-bit generator. It takes the demodulated OOK bitstream from an RF receiver pin. It recovers 12 tri-state code bits (0, 1, F) framed by a sync bit, and qualifies the code by requiring consecutive identical frames, in the manner of a PT2272. Decoded codes go to the design core as a 24-bit word with a one-cycle valid strobe.

---
 rtl/pt_decoder_if.sv | 11 +
 rtl/pt_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pt_decoder_if.sv
// pt_decoder_if: OOK receiver pin in, qualified PT2262 code out.
// master = decoder side, slave = design-core / stimulus side.
interface pt_decoder_if;
    logic        din;
    logic [23:0] code;
    logic        valid;
    logic        err;

    modport master (input din, output code, valid, err);
    modport slave  (output din, input code, valid, err);
endinterface

// File: rtl/pt_decoder.sv
// pt_decoder: PT2272-style receiver for PT2262 tri-state frames.
// Recovers 12 trits after a sync gap and qualifies them by repetition.
module pt_decoder #(
    parameter int ALPHA  = 8,
    parameter int REPEAT = 2
) (
    input logic          clk,
    input logic          reset,
    pt_decoder_if.master bus
);

    localparam int RUN_MAX = 64 * ALPHA;
    localparam int RW      = $clog2(RUN_MAX + 1);

    localparam logic [RW-1:0] T_SHORT = RW'(2 * ALPHA);
    localparam logic [RW-1:0] T_LONG  = RW'(8 * ALPHA);
    localparam logic [RW-1:0] T_BAD   = RW'(16 * ALPHA);
    localparam logic [RW-1:0] T_SYNC  = RW'(RUN_MAX);
    localparam logic [3:0]    REP     = 4'(REPEAT);
    localparam logic [4:0]    P_SYNC  = 5'd24;

    typedef enum logic [1:0] {HUNT, GAP, HIGH, LOW} state_t;

    state_t        state, state_n;
    logic          s1, s, s_q;
    logic [RW-1:0] run, run_q;
    logic [4:0]    pidx, pidx_n;
    logic          hi_long, hi_long_n;
    logic          p0, p0_n;
    logic [23:0]   shift, shift_n;
    logic [23:0]   cand, cand_n;
    logic [23:0]   code_q, code_n;
    logic [3:0]    mcnt, mcnt_n, mcnt_new;
    logic          valid_q, valid_n;
    logic          err_q, err_n;
    logic          rise, fall, w_short, w_long;
    logic          narrow, wide, same, done, bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            s_q   <= 1'b0;
            run_q <= '0;
        end else begin
            s1    <= bus.din;
            s     <= s1;
            s_q   <= s;
            run_q <= run;
        end
    end

    // run tracks s in the same cycle; run_q holds the length of the run an edge ends
    always_comb begin
        if (s != s_q)
            run = RW'(1);
        else if (run_q == T_SYNC)
            run = T_SYNC;
        else
            run = run_q + RW'(1);
    end

    assign rise     = s & ~s_q;
    assign fall     = ~s & s_q;
    assign w_short  = (run_q >= T_SHORT) && (run_q < T_LONG);
    assign w_long   = (run_q >= T_LONG) && (run_q < T_BAD);
    assign narrow   = ~hi_long & w_long;
    assign wide     = hi_long & w_short;
    assign same     = (shift == cand) && (mcnt != 4'd0);
    assign mcnt_new = !same ? 4'd1 : (mcnt == REP) ? REP : mcnt + 4'd1;

    always_comb begin
        state_n   = state;
        pidx_n    = pidx;
        hi_long_n = hi_long;
        p0_n      = p0;
        shift_n   = shift;
        cand_n    = cand;
        mcnt_n    = mcnt;
        code_n    = code_q;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        done      = 1'b0;
        bad       = 1'b0;
        unique case (state)
            HUNT: begin
                if (!s && run == T_SYNC)
                    state_n = GAP;
            end
            GAP: begin
                if (rise) begin
                    pidx_n  = '0;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (s && run == T_BAD)
                    bad = 1'b1;
                else if (fall) begin
                    if (w_short || (w_long && pidx != P_SYNC)) begin
                        hi_long_n = w_long;
                        state_n   = LOW;
                    end else
                        bad = 1'b1;
                end
            end
            LOW: begin
                if (pidx == P_SYNC) begin
                    if (rise)
                        bad = 1'b1;
                    else if (run == T_SYNC)
                        done = 1'b1;
                end else if (!s && run == T_BAD)
                    bad = 1'b1;
                else if (rise) begin
                    // second pulse of a bit: trit = {first wide, second wide}
                    if (!(narrow || wide) || (pidx[0] && p0 && !wide))
                        bad = 1'b1;
                    else begin
                        if (pidx[0])
                            shift_n = {shift[21:0], p0, wide};
                        else
                            p0_n = wide;
                        pidx_n  = pidx + 5'd1;
                        state_n = HIGH;
                    end
                end
            end
            default: state_n = HUNT;
        endcase
        if (done) begin
            cand_n  = shift;
            mcnt_n  = mcnt_new;
            state_n = GAP;
            if (mcnt_new == REP) begin
                valid_n = 1'b1;
                code_n  = shift;
            end
        end
        if (bad) begin
            err_n   = 1'b1;
            mcnt_n  = '0;
            state_n = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HUNT;
            pidx    <= '0;
            hi_long <= 1'b0;
            p0      <= 1'b0;
            shift   <= '0;
            cand    <= '0;
            mcnt    <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            pidx    <= pidx_n;
            hi_long <= hi_long_n;
            p0      <= p0_n;
            shift   <= shift_n;
            cand    <= cand_n;
            mcnt    <= mcnt_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;

endmodule
